// File: rtl/leaf_stream_pkg.sv
// rtl/leaf_stream_pkg.sv - shared defaults and watermark helper for the leaf stream FIFO
package leaf_stream_pkg;

  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int DEF_DEPTH_BITS   = 4;
  localparam int DEF_AFULL_SLACK  = 2;
  localparam int STAT_BITS        = 32;

  // almost_full when the number of free entries has fallen to the slack or below
  function automatic logic almost_full_calc(input int unsigned occ,
                                            input int unsigned depth,
                                            input int unsigned slack);
    return (depth - occ) <= slack;
  endfunction

endpackage

// File: rtl/leaf_fifo_ram.sv
// rtl/leaf_fifo_ram.sv - FIFO storage: one synchronous write port, one asynchronous read port, no reset
module leaf_fifo_ram
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int ADDR_BITS    = DEF_DEPTH_BITS
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [PAYLOAD_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [PAYLOAD_BITS-1:0] rdata
);

  logic [PAYLOAD_BITS-1:0] mem [1 << ADDR_BITS];

  // contents are never reset; the controller decides what is meaningful
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/leaf_stream_fifo.sv
// rtl/leaf_stream_fifo.sv - elastic vld/ack stream FIFO with occupancy, watermark and optional stats (LEAF_FIFO_STATS_EN)
module leaf_stream_fifo
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int DEPTH_BITS   = DEF_DEPTH_BITS,
  parameter int AFULL_SLACK  = DEF_AFULL_SLACK
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic [DEPTH_BITS:0]     count,
  output logic                    almost_full,
  output logic [STAT_BITS-1:0]    stat_in,
  output logic [STAT_BITS-1:0]    stat_out,
  output logic [DEPTH_BITS:0]     stat_max
);

  localparam int                DEPTH     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] LAST_IDX = DEPTH_BITS'(DEPTH - 1);

  logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]     count_q, count_next;
  logic                    ready_q;
  logic                    wr_wrapped;
  logic                    wr_en, rd_en;
  logic [PAYLOAD_BITS-1:0] ram_rdata;

  assign din_ack  = ready_q;
  assign dout_vld = (count_q != '0);
  assign wr_en    = din_vld & ready_q;
  assign rd_en    = dout_ack & dout_vld;
  assign count    = count_q;

  assign almost_full = almost_full_calc(32'(count_q), 32'(DEPTH), 32'(AFULL_SLACK));

  // until every slot has been written once since reset, an empty FIFO shows zero instead of pre-reset data
  assign dout = (dout_vld || wr_wrapped) ? ram_rdata : '0;

  // occupancy moves only when exactly one side transfers
  always_comb begin
    count_next = count_q;
    if (wr_en && !rd_en)      count_next = count_q + 1'b1;
    else if (!wr_en && rd_en) count_next = count_q - 1'b1;
  end

  // pointers, occupancy and the registered ready flag; ready stays low until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      wr_wrapped <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && wr_ptr == LAST_IDX) wr_wrapped <= 1'b1;
      count_q <= count_next;
      ready_q <= (count_next != DEPTH_CNT);
    end
  end

  leaf_fifo_ram #(
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .ADDR_BITS   (DEPTH_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

`ifdef LEAF_FIFO_STATS_EN
  logic [STAT_BITS-1:0] stat_in_q, stat_out_q;
  logic [DEPTH_BITS:0]  stat_max_q;

  // transfer counters wrap freely; the high-water mark tracks the occupancy about to be registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
      stat_max_q <= '0;
    end else begin
      if (wr_en) stat_in_q <= stat_in_q + 1'b1;
      if (rd_en) stat_out_q <= stat_out_q + 1'b1;
      if (count_next > stat_max_q) stat_max_q <= count_next;
    end
  end

  assign stat_in  = stat_in_q;
  assign stat_out = stat_out_q;
  assign stat_max = stat_max_q;
`else
  assign stat_in  = '0;
  assign stat_out = '0;
  assign stat_max = '0;
`endif

endmodule
